// File: rtl/uart_tx_feeder_if.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder_if
//
// Signal bundle between a byte producer, the uart_tx_feeder and the UART's
// bus register port.
//
//   Stream side : IN_VALID, IN_DATA (producer -> feeder), IN_READY (back)
//   UART side   : UART_RD, UART_WR, UART_BE, UART_DO (feeder -> UART),
//                 UART_DI (UART -> feeder, bit 0 = transmitter busy)
//
// Modports:
//   slave  - the feeder itself (sinks the stream, drives the UART bus)
//   master - the environment around it (producer plus UART)
// -----------------------------------------------------------------------------
interface uart_tx_feeder_if;
    logic        IN_VALID;
    logic [7:0]  IN_DATA;
    logic        IN_READY;
    logic        UART_RD;
    logic        UART_WR;
    logic [3:0]  UART_BE;
    logic [31:0] UART_DO;
    logic [31:0] UART_DI;

    modport slave (
        input  IN_VALID, IN_DATA, UART_DI,
        output IN_READY, UART_RD, UART_WR, UART_BE, UART_DO
    );

    modport master (
        output IN_VALID, IN_DATA, UART_DI,
        input  IN_READY, UART_RD, UART_WR, UART_BE, UART_DO
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_feeder
//
// Buffers bytes from a valid/ready producer in a small circular FIFO and
// drains them into the UART's register interface. Before each transmit-buffer
// write the status register is polled, and the write is issued only once the
// transmitter reports not busy, so the single-entry UART TX register never
// has a byte overwritten.
//
// Parameters:
//   DEPTH_LOG2 - log2 of FIFO depth (legal 1..8, default 4 = 16 entries)
//
// Ports:
//   CLK   - clock
//   RES   - asynchronous, active-high reset (deassertion synchronised by
//           the integrator)
//   bus   - uart_tx_feeder_if.slave: producer stream and UART bus signals
//   COUNT - FIFO occupancy, 0..2^DEPTH_LOG2
//   IDLE  - FIFO empty and FSM in S_IDLE
//
// Build option:
//   UART_TXF_CRLF_EN - when defined, every 8'h0A is preceded on the UART by
//                      an inserted 8'h0D. COUNT still counts source bytes.
// -----------------------------------------------------------------------------
module uart_tx_feeder #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                CLK,
    input  logic                RES,
    uart_tx_feeder_if.slave     bus,
    output logic [DEPTH_LOG2:0] COUNT,
    output logic                IDLE
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_POLL,
        S_WRITE,
        S_SETTLE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                push;
    logic                pop;
    logic [7:0]          head_byte;
    logic [7:0]          tx_byte;
    logic                xmit_busy;
    logic                unused_di;

    // Only the busy flag of the status word matters here.
    assign xmit_busy = bus.UART_DI[0];
    assign unused_di = ^bus.UART_DI[31:1];

    // Pointers carry one extra bit so that full and empty are distinguishable;
    // their difference is the occupancy directly, wrapping included.
    assign COUNT        = wr_ptr - rd_ptr;
    assign bus.IN_READY = (COUNT != FULL_COUNT);
    assign push         = bus.IN_VALID && bus.IN_READY;
    assign head_byte    = mem[rd_ptr[DEPTH_LOG2-1:0]];
    assign IDLE         = (COUNT == '0) && (state == S_IDLE);

    // S_WRITE is only reachable through S_POLL, which is only entered with a
    // non-empty FIFO, so a pop here can never underflow.
`ifdef UART_TXF_CRLF_EN
    logic cr_sent;
    logic cr_insert;

    // First visit to a line feed sends CR and keeps the LF at the head; the
    // second visit sends the LF itself and pops it.
    assign cr_insert = (head_byte == 8'h0A) && !cr_sent;
    assign tx_byte   = cr_insert ? 8'h0D : head_byte;
    assign pop       = (state == S_WRITE) && !cr_insert;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            cr_sent <= 1'b0;
        end else if (state == S_WRITE) begin
            cr_sent <= cr_insert;
        end
    end
`else
    assign tx_byte = head_byte;
    assign pop     = (state == S_WRITE);
`endif

    // NOTE: the storage array has no reset; stale entries are never read
    // because reads are gated by the pointers, which are reset.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.IN_DATA;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. Busy polling has no timeout on purpose; the UART is
    // guaranteed to finish its current character eventually.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned
        // and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:   if (COUNT != '0) state_nxt = S_POLL;
            S_POLL:   if (!xmit_busy)  state_nxt = S_WRITE;
            S_WRITE:  state_nxt = S_SETTLE;
            S_SETTLE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs decoded from the state register only. The data word
    // depends on FIFO contents, never on IN_* or UART_DI.
    always_comb begin
        bus.UART_RD = 1'b0;
        bus.UART_WR = 1'b0;
        bus.UART_BE = 4'b0000;
        bus.UART_DO = 32'h0;
        case (state)
            S_POLL: begin
                bus.UART_RD = 1'b1;
                bus.UART_BE = 4'b0001;
            end
            S_WRITE: begin
                bus.UART_WR = 1'b1;
                bus.UART_BE = 4'b0010;
                bus.UART_DO = {16'h0, tx_byte, 8'h0};
            end
            default: ;
        endcase
    end

endmodule
